// File: rtl/sd_sector_stream_reader_if.sv
// Read-engine handshake and output stream of the SD sector stream reader.
// The master side is the reader; the slave side is the read engine plus consumer.
interface sd_sector_stream_reader_if #(
   parameter int DATA_W = 16
);
   logic              rd_start_en;
   logic [31:0]       rd_sec_addr;
   logic              rd_busy;
   logic              rd_val_en;
   logic [DATA_W-1:0] rd_val_data;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;

   modport master (
      output rd_start_en, rd_sec_addr, out_valid, out_data,
      input  rd_busy, rd_val_en, rd_val_data, out_ready
   );

   modport slave (
      input  rd_start_en, rd_sec_addr, out_valid, out_data,
      output rd_busy, rd_val_en, rd_val_data, out_ready
   );
endinterface

// File: rtl/sd_sector_stream_reader.sv
// Walks a sector range through the SD read engine and streams the returned
// words out of a first-word-fall-through FIFO, admitting a sector only when it fits.
module sd_sector_stream_reader #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 1024,
   parameter int SEC_BYTES  = 512
) (
   input  logic                         sd_clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic                         loop_mode,
   input  logic [31:0]                  start_section,
   input  logic [31:0]                  end_section,
   input  logic                         sd_init_done,
   sd_sector_stream_reader_if.master    bus,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         done,
   output logic                         ovf_err,
   output logic                         range_err
);
   localparam int WPS = SEC_BYTES * 8 / DATA_W;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_SPACE,
      ST_ISSUE,
      ST_WAIT_BUSY_HI,
      ST_WAIT_BUSY_LO,
      ST_NEXT,
      ST_DONE
   } state_t;

   state_t            state;
   logic [31:0]       cur;
   logic [31:0]       start_q;
   logic [31:0]       end_q;
   logic              loop_q;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [LW-1:0]     space;
   logic              run_start;
   logic              full;
   logic              push;
   logic              pop;
   logic              space_ok;

   assign run_start     = (state == ST_IDLE) && enable && sd_init_done;
   assign full          = (fifo_level == LW'(FIFO_DEPTH));
   assign bus.out_valid = (fifo_level != '0);
   assign bus.out_data  = mem[rd_ptr];
   assign pop           = bus.out_valid && bus.out_ready;
   // a full FIFO still takes a word when the same cycle pops one
   assign push          = bus.rd_val_en && (!full || pop);
   assign space         = LW'(FIFO_DEPTH) - fifo_level;
   assign space_ok      = (space >= LW'(WPS));

   always_ff @(posedge sd_clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.rd_val_data;
      end
   end

   always_ff @(posedge sd_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         ovf_err    <= 1'b0;
      end else if (run_start) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         ovf_err    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop) begin
            fifo_level <= fifo_level + 1'b1;
         end else if (pop && !push) begin
            fifo_level <= fifo_level - 1'b1;
         end
         if (bus.rd_val_en && !push) ovf_err <= 1'b1;
      end
   end

   always_ff @(posedge sd_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         cur             <= '0;
         start_q         <= '0;
         end_q           <= '0;
         loop_q          <= 1'b0;
         bus.rd_start_en <= 1'b0;
         bus.rd_sec_addr <= '0;
         done            <= 1'b0;
         range_err       <= 1'b0;
      end else begin
         bus.rd_start_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run_start) begin
                  start_q <= start_section;
                  end_q   <= end_section;
                  loop_q  <= loop_mode;
                  cur     <= start_section;
                  done    <= 1'b0;
                  if (end_section < start_section) begin
                     range_err <= 1'b1;
                     done      <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     range_err <= 1'b0;
                     state     <= ST_WAIT_SPACE;
                  end
               end
            end
            ST_WAIT_SPACE: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (space_ok) begin
                  // pulse is raised on entry so it coincides with ST_ISSUE
                  bus.rd_start_en <= 1'b1;
                  bus.rd_sec_addr <= cur;
                  state           <= ST_ISSUE;
               end
            end
            ST_ISSUE:        state <= ST_WAIT_BUSY_HI;
            ST_WAIT_BUSY_HI: if (bus.rd_busy)  state <= ST_WAIT_BUSY_LO;
            ST_WAIT_BUSY_LO: if (!bus.rd_busy) state <= ST_NEXT;
            ST_NEXT: begin
               if (!enable) begin
                  state <= ST_IDLE;
               end else if (cur != end_q) begin
                  cur   <= cur + 32'd1;
                  state <= ST_WAIT_SPACE;
               end else if (loop_q) begin
                  cur   <= start_q;
                  state <= ST_WAIT_SPACE;
               end else begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (!enable) begin
                  done  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: doc/sd_sector_stream_reader.md
Name: sd_sector_stream_reader

Overview:
- Single-clock streaming SD sector reader.
- Walks sector addresses start_section..end_section and drives the SD read engine through a start/busy handshake.
- Buffers returned words in an internal synchronous FIFO of parametrised width and depth.
- Presents the buffered data on a valid/ready stream.
- Adds over the previous generation: one-shot or loop mode, space-based sector admission, flush on run start, done, overflow and range-error status.

Parameters:
- DATA_W, 16, read-engine and stream word width; legal values 8, 16, 32.
- FIFO_DEPTH, 1024, FIFO words; power of 2, at least 2*WPS.
- SEC_BYTES, 512, bytes per sector.
- Derived: WPS = SEC_BYTES*8/DATA_W (256 at the defaults); LW = log2(FIFO_DEPTH)+1.

Ports:
- sd_clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request, level-sensitive.
- loop_mode  in  1  1 = wrap to start_section after end_section; 0 = stop after one pass. Sampled at run start.
- start_section  in  32  first sector; sampled at run start.
- end_section  in  32  last sector, inclusive; sampled at run start.
- sd_init_done  in  1  SD card initialised.
- rd_start_en  out  1  one-cycle read-start pulse.
- rd_sec_addr  out  32  sector address; stable from the pulse until busy falls.
- rd_busy  in  1  read engine busy.
- rd_val_en  in  1  read word valid.
- rd_val_data  in  DATA_W  read word.
- out_valid  out  1  FIFO not empty.
- out_data  out  DATA_W  FIFO head word, first-word-fall-through.
- out_ready  in  1  consumer accepts the word.
- fifo_level  out  LW  FIFO occupancy, 0..FIFO_DEPTH.
- done  out  1  one-shot pass complete.
- ovf_err  out  1  sticky: a word was dropped because the FIFO was full.
- range_err  out  1  sticky: end_section < start_section at run start.

Behaviour:
- Reset values: rd_start_en=0, rd_sec_addr=0, out_valid=0, fifo_level=0, done=0, ovf_err=0, range_err=0. FSM in IDLE, FIFO empty. Reset mid-transfer aborts immediately; in-flight words are lost.
- Run start: in IDLE, enable=1 and sd_init_done=1 for one cycle. That cycle:
  - latches start_section, end_section and loop_mode;
  - flushes the FIFO (fifo_level goes to 0 next cycle);
  - clears done, ovf_err and range_err;
  - loads cur=start_section.
- If end < start at run start: range_err=1, go to DONE, no reads issued.
- FSM states:
  - IDLE: run start as above; otherwise stay.
  - WAIT_SPACE: if enable=0, go to IDLE. Else if FIFO_DEPTH - fifo_level >= WPS, go to ISSUE.
  - ISSUE: rd_start_en=1 for exactly 1 cycle with rd_sec_addr=cur; go to WAIT_BUSY_HI.
  - WAIT_BUSY_HI: go to WAIT_BUSY_LO when rd_busy=1.
  - WAIT_BUSY_LO: go to NEXT when rd_busy=0.
  - NEXT:
    - if enable=0: go to IDLE;
    - else if cur != end: cur=cur+1, go to WAIT_SPACE;
    - else if loop_mode=1: cur=start, go to WAIT_SPACE;
    - else: go to DONE.
  - DONE: done=1 and holds while enable=1. When enable=0: done=0, go to IDLE.
- Deasserting enable mid-sector does not abort the sector. The FSM finishes the busy handshake and accepts all its words; the FIFO is not flushed.
- cur increments modulo 2^32. end=0xFFFFFFFF is legal and ends the pass without overflow.
- FIFO push: rd_val_en=1, in any state.
  - Not full: word written.
  - Full with a pop in the same cycle: both occur, level unchanged.
  - Full without a pop: word dropped, ovf_err=1.
- FIFO pop: out_valid && out_ready. out_data is valid combinationally from registered FIFO state whenever out_valid=1. A word pushed into an empty FIFO appears on out_valid one cycle later.
- fifo_level = pushes - pops, registered; push and pop in the same cycle leave it unchanged.
- The flush on run start takes priority over a same-cycle push or pop.
- The admission rule guarantees no overflow with a conforming read engine (at most WPS words per start). ovf_err therefore flags engine misbehaviour.

Test Plan:
1. DATA_W=16, start=100, end=102, loop_mode=0, out_ready=1, model returns 256 words/sector -> rd_start_en at addrs 100, 101, 102 exactly once each; 768 words out in order; done=1; no 4th pulse.
2. loop_mode=1, start=end=5, out_ready=0 -> 4 sectors issued (level 1024 at FIFO_DEPTH=1024, no 5th issue while level>768); raise out_ready -> issuing resumes, address stays 5.
3. start=10, end=9 -> range_err=1, done=1, zero rd_start_en; enable low then high with start=9, end=10 -> range_err clears.
4. Model returns 300 words into a FIFO with level 900, out_ready=0 -> level saturates at 1024, ovf_err=1; simultaneous pop when full keeps level 1024 without setting ovf_err.
5. enable dropped mid-sector -> sector completes, all 256 words enter the FIFO, FSM goes to IDLE; re-enable -> FIFO flushed (level=0), ovf_err cleared.
6. rst_n pulsed low during WAIT_BUSY_LO -> next cycle all outputs at reset values, level=0.
